// File: rtl/output_mem_ctrl.sv
// output_mem_ctrl: collects N_WORDS upstream result words into output memory and hands the frame downstream
module output_mem_ctrl #(
  parameter int N_WORDS = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 3
) (
  input  logic              Clock,
  input  logic              Res,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              En_out_mem,
  output logic [ADDR_W-1:0] Addr_mem_o,
  output logic [DATA_W-1:0] mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [ADDR_W-1:0] word_cnt
);
  localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, DONE = 2'd2;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_WORDS - 1);
  logic [1:0] state;
  // handshake and write-port decode; reset blanks everything upstream can see
  always_comb begin
    in_ready   = !Res && state == FILL;
    En_out_mem = in_ready && in_valid;
    Addr_mem_o = word_cnt;
    mem_data   = in_data;
    out_valid  = state == DONE;
    busy       = !Res && state != IDLE;
  end
  // frame sequencing: count accepted words, park in DONE until downstream drains
  always_ff @(posedge Clock) begin
    if (Res) begin
      state    <= IDLE;
      word_cnt <= '0;
    end else if (state == IDLE && start) begin
      state    <= FILL;
      word_cnt <= '0;
    end else if (En_out_mem) begin
      word_cnt <= word_cnt + 1'b1;
      if (word_cnt == LAST) state <= DONE;
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
endmodule
